// File: rtl/mem_write_checker.sv
// Data-memory write monitor: compares the DUT's memory writes against a preloaded table of
// expected (addr,data) pairs and reports pass, or fail with a cause code.
module mem_write_checker #(
  parameter int unsigned  N       = 16,
  parameter int unsigned  A       = 16,
  parameter int unsigned  DEPTH   = 8,
  parameter int unsigned  TIMEOUT = 1024,
  parameter bit           ORDERED = 1'b1,
  parameter bit           STRICT  = 1'b0,
  localparam int unsigned CW      = $clog2(DEPTH + 1),
  localparam int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [A-1:0]  load_addr,
  input  logic [N-1:0]  load_data,
  output logic          load_ready,
  input  logic          start,
  input  logic          memwrite,
  input  logic [A-1:0]  dataadr,
  input  logic [N-1:0]  writedata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [1:0]    fail_code,
  output logic [CW-1:0] match_count,
  output logic [TW-1:0] cycle_count,
  output logic [A-1:0]  bad_addr,
  output logic [N-1:0]  bad_data
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] CodeNone     = 2'd0;
  localparam logic [1:0] CodeMismatch = 2'd1;
  localparam logic [1:0] CodeTimeout  = 2'd2;
  localparam logic [1:0] CodeUnexp    = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

  state_e           state_q;
  logic [A-1:0]     ent_addr_q [DEPTH];
  logic [N-1:0]     ent_data_q [DEPTH];
  logic [CW-1:0]    entry_count_q;
  logic [DEPTH-1:0] matched_q;

  logic             load_accept;
  logic             addr_hit;
  logic             data_hit;
  logic [IW-1:0]    cand_idx;
  logic             last_match;
  logic [TW-1:0]    cycle_next;
  logic             timeout_hit;

  assign load_ready  = (state_q == StIdle) && (entry_count_q < CW'(DEPTH));
  assign load_accept = load_valid && load_ready;

  assign busy = (state_q == StRun);
  assign done = (state_q == StPass) || (state_q == StFail);
  assign pass = (state_q == StPass);

  // Ordered mode only ever looks at the next entry; unordered picks the lowest-index
  // unmatched entry with a matching address (loop runs high-to-low so the lowest wins).
  always_comb begin
    addr_hit = 1'b0;
    cand_idx = '0;
    if (ORDERED) begin
      cand_idx = IW'(match_count);
      addr_hit = (ent_addr_q[cand_idx] == dataadr);
    end else begin
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if ((i < int'(entry_count_q)) && !matched_q[i] && (ent_addr_q[i] == dataadr)) begin
          addr_hit = 1'b1;
          cand_idx = IW'(i);
        end
      end
    end
  end

  assign data_hit    = (ent_data_q[cand_idx] == writedata);
  assign last_match  = ((match_count + CW'(1)) == entry_count_q);
  assign cycle_next  = (cycle_count == TW'(TIMEOUT)) ? cycle_count : cycle_count + TW'(1);
  assign timeout_hit = (cycle_next == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      entry_count_q <= '0;
      matched_q     <= '0;
      fail_code     <= CodeNone;
      match_count   <= '0;
      cycle_count   <= '0;
      bad_addr      <= '0;
      bad_data      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (load_accept) begin
            ent_addr_q[IW'(entry_count_q)] <= load_addr;
            ent_data_q[IW'(entry_count_q)] <= load_data;
            entry_count_q                  <= entry_count_q + CW'(1);
          end
          // A load accepted in the same cycle as start counts towards the run.
          if (start) begin
            if ((entry_count_q == '0) && !load_accept) begin
              state_q   <= StFail;
              fail_code <= CodeUnexp;
            end else begin
              state_q <= StRun;
            end
          end
        end

        StRun: begin
          cycle_count <= cycle_next;
          if (memwrite && addr_hit && data_hit) begin
            match_count         <= match_count + CW'(1);
            matched_q[cand_idx] <= 1'b1;
          end

          if (memwrite && addr_hit && data_hit && last_match) begin
            state_q <= StPass;
          end else if (memwrite && addr_hit && !data_hit) begin
            state_q   <= StFail;
            fail_code <= CodeMismatch;
            bad_addr  <= dataadr;
            bad_data  <= writedata;
          end else if (memwrite && !addr_hit && STRICT) begin
            state_q   <= StFail;
            fail_code <= CodeUnexp;
            bad_addr  <= dataadr;
            bad_data  <= writedata;
          end else if (timeout_hit) begin
            state_q   <= StFail;
            fail_code <= CodeTimeout;
          end
        end

        StPass, StFail: begin
          if (start) begin
            matched_q   <= '0;
            match_count <= '0;
            cycle_count <= '0;
            bad_addr    <= '0;
            bad_data    <= '0;
            // An empty table can never pass; report it again rather than run to timeout.
            if (entry_count_q == '0) begin
              state_q   <= StFail;
              fail_code <= CodeUnexp;
            end else begin
              state_q   <= StRun;
              fail_code <= CodeNone;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
